snake_motion_controller: RTL and testbench

Sequencer for the snake head render object. Consumes control packets from packet-router port 0, filters illegal direction changes, and paces movement to the video frame rate. On each step it emits one single-beat MOVE packet to `render_object_snake_head`, so the head advances exactly once per step instead of once per raw input packet.

---
 rtl/snake_motion_controller_pkg.sv | 56 +++++
 rtl/snake_step_timer.sv | 37 +++
 rtl/snake_motion_controller.sv | 147 ++++++++++++++
 tb/tb_snake_motion_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_motion_controller_pkg.sv
// Shared encodings, packet layouts and direction helpers for the snake head sequencer.
package snake_motion_controller_pkg;

    localparam int unsigned AXIS_W = 64;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PKT_STEP_W = 16;

    localparam logic [BYTE_W-1:0] OP_MOVE   = 8'h01;
    localparam logic [BYTE_W-1:0] OP_PAUSE  = 8'h02;
    localparam logic [BYTE_W-1:0] OP_RESUME = 8'h03;

    localparam logic [BYTE_W-1:0] DIR_NONE  = 8'd0;
    localparam logic [BYTE_W-1:0] DIR_UP    = 8'd1;
    localparam logic [BYTE_W-1:0] DIR_DOWN  = 8'd2;
    localparam logic [BYTE_W-1:0] DIR_LEFT  = 8'd3;
    localparam logic [BYTE_W-1:0] DIR_RIGHT = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Inbound control beat: opcode in byte0, direction in byte1.
    typedef struct packed {
        logic [AXIS_W-2*BYTE_W-1:0] rsvd;
        logic [BYTE_W-1:0]          dir;
        logic [BYTE_W-1:0]          opcode;
    } ctrl_pkt_t;

    // Outbound MOVE beat to the snake head.
    typedef struct packed {
        logic [AXIS_W-PKT_STEP_W-2*BYTE_W-1:0] rsvd;
        logic [PKT_STEP_W-1:0]                 step;
        logic [BYTE_W-1:0]                     dir;
        logic [BYTE_W-1:0]                     opcode;
    } move_pkt_t;

    function automatic logic dir_valid(input logic [BYTE_W-1:0] d);
        return (d >= DIR_UP) && (d <= DIR_RIGHT);
    endfunction

    function automatic logic [BYTE_W-1:0] dir_opposite(input logic [BYTE_W-1:0] d);
        logic [BYTE_W-1:0] opp;
        case (d)
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_RIGHT: opp = DIR_LEFT;
            default:   opp = DIR_NONE;
        endcase
        return opp;
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame-tick divider: pulses o_step on the tick that completes a step period.
module snake_step_timer #(
    parameter int unsigned FPS_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic             i_frame_tick,
    input  logic [FPS_W-1:0] i_frames_per_step,
    output logic             o_step
);

    logic [FPS_W-1:0] frame_cnt;
    logic [FPS_W-1:0] last_cnt;

    // A divider of 0 behaves like 1; >= recovers if the divider shrinks mid-period.
    always_comb begin
        last_cnt = '0;
        if (i_frames_per_step != '0) begin
            last_cnt = i_frames_per_step - FPS_W'(1);
        end
    end

    assign o_step = i_run & i_frame_tick & (frame_cnt >= last_cnt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
        end else if (i_clear) begin
            frame_cnt <= '0;
        end else if (i_run && i_frame_tick) begin
            frame_cnt <= o_step ? '0 : frame_cnt + FPS_W'(1);
        end
    end

endmodule

// File: rtl/snake_motion_controller.sv
// Snake head sequencer: filters direction changes from port-0 control packets and
// emits one MOVE beat per frame-paced step.
module snake_motion_controller
    import snake_motion_controller_pkg::*;
#(
    parameter int unsigned FPS_W      = 8,
    parameter int unsigned STEP_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [AXIS_W-1:0]     i_s_axis_tdata,
    input  logic                  i_s_axis_tvalid,
    input  logic                  i_s_axis_tlast,
    output logic                  o_s_axis_tready,
    input  logic                  i_frame_tick,
    input  logic [FPS_W-1:0]      i_frames_per_step,
    input  logic                  i_collision,
    output logic [AXIS_W-1:0]     o_m_axis_tdata,
    output logic                  o_m_axis_tvalid,
    output logic                  o_m_axis_tlast,
    input  logic                  i_m_axis_tready,
    output logic [BYTE_W-1:0]     o_direction,
    output logic [STEP_CNT_W-1:0] o_step_count,
    output logic [1:0]            o_state,
    output logic                  o_overrun
);

    state_e                  state;
    logic [BYTE_W-1:0]       pending_dir;
    move_pkt_t               out_pkt;

    ctrl_pkt_t               in_pkt;
    logic                    pkt_acc;
    logic                    is_move;
    logic                    is_pause;
    logic                    is_resume;
    logic                    timer_step;
    logic                    step_fire;
    logic                    out_busy;
    logic                    step_commit;
    logic                    step_drop;
    logic [BYTE_W-1:0]       eff_dir;
    logic                    move_legal;
    logic                    start_run;
    logic [STEP_CNT_W-1:0]   step_cnt_nxt;
    logic                    unused_rsvd;

    assign o_s_axis_tready = 1'b1;

    // Only the closing beat of a packet carries a command.
    assign in_pkt      = ctrl_pkt_t'(i_s_axis_tdata);
    assign unused_rsvd = ^in_pkt.rsvd;
    assign pkt_acc     = i_s_axis_tvalid & i_s_axis_tlast;
    assign is_move     = pkt_acc & (in_pkt.opcode == OP_MOVE);
    assign is_pause    = pkt_acc & (in_pkt.opcode == OP_PAUSE);
    assign is_resume   = pkt_acc & (in_pkt.opcode == OP_RESUME);

    snake_step_timer #(
        .FPS_W (FPS_W)
    ) u_step_timer (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_run             (state == ST_RUN),
        .i_clear           (start_run),
        .i_frame_tick      (i_frame_tick),
        .i_frames_per_step (i_frames_per_step),
        .o_step            (timer_step)
    );

    // A step is lost, not delayed, when the head still holds the previous MOVE.
    assign step_fire    = timer_step & ~i_collision;
    assign out_busy     = o_m_axis_tvalid & ~i_m_axis_tready;
    assign step_commit  = step_fire & ~out_busy;
    assign step_drop    = step_fire & out_busy;
    assign step_cnt_nxt = o_step_count + STEP_CNT_W'(1);

    // Reversal is judged against the direction that will be in force after this edge.
    assign eff_dir    = step_commit ? pending_dir : o_direction;
    assign move_legal = is_move & dir_valid(in_pkt.dir)
                      & (in_pkt.dir != dir_opposite(eff_dir));
    assign start_run  = (state == ST_IDLE) & is_move & dir_valid(in_pkt.dir) & ~i_collision;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else if (i_collision) begin
            state <= ST_HALT;
        end else begin
            case (state)
                ST_IDLE:  if (start_run) state <= ST_RUN;
                ST_RUN:   if (is_pause)  state <= ST_PAUSE;
                ST_PAUSE: if (is_resume) state <= ST_RUN;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Pending holds the last legal request; committed tracks what the head is doing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_dir <= DIR_NONE;
            o_direction <= DIR_NONE;
        end else begin
            if (start_run) begin
                pending_dir <= in_pkt.dir;
                o_direction <= in_pkt.dir;
            end else begin
                if (((state == ST_RUN) || (state == ST_PAUSE)) && move_legal) begin
                    pending_dir <= in_pkt.dir;
                end
                if (step_commit) begin
                    o_direction <= pending_dir;
                end
            end
        end
    end

    // Output register slice; a commit in the handshake cycle reloads valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m_axis_tvalid <= 1'b0;
            out_pkt         <= '0;
            o_step_count    <= '0;
            o_overrun       <= 1'b0;
        end else begin
            if (step_commit) begin
                o_m_axis_tvalid <= 1'b1;
                out_pkt         <= '{rsvd:   '0,
                                     step:   PKT_STEP_W'(step_cnt_nxt),
                                     dir:    pending_dir,
                                     opcode: OP_MOVE};
                o_step_count    <= step_cnt_nxt;
            end else if (i_m_axis_tready) begin
                o_m_axis_tvalid <= 1'b0;
            end
            if (step_drop) begin
                o_overrun <= 1'b1;
            end
        end
    end

    assign o_m_axis_tdata = out_pkt;
    assign o_m_axis_tlast = o_m_axis_tvalid;
    assign o_state        = state;

endmodule

// File: tb/tb_snake_motion_controller.sv
// Bench for snake_motion_controller: directed scenarios plus randomized traffic
// against a per-cycle behavioural model of the game rules.
module tb_snake_motion_controller;

    logic        i_clk;
    logic        i_rst_n;
    logic [63:0] i_s_axis_tdata;
    logic        i_s_axis_tvalid;
    logic        i_s_axis_tlast;
    logic        o_s_axis_tready;
    logic        i_frame_tick;
    logic [7:0]  i_frames_per_step;
    logic        i_collision;
    logic [63:0] o_m_axis_tdata;
    logic        o_m_axis_tvalid;
    logic        o_m_axis_tlast;
    logic        i_m_axis_tready;
    logic [7:0]  o_direction;
    logic [15:0] o_step_count;
    logic [1:0]  o_state;
    logic        o_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: game mode 0 idle, 1 run, 2 pause, 3 halt.
    int          m_state, m_pend, m_dir, m_cnt, m_steps;
    bit          m_valid, m_over;
    logic [63:0] m_data;

    snake_motion_controller #(
        .FPS_W      (8),
        .STEP_CNT_W (16)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_s_axis_tdata    (i_s_axis_tdata),
        .i_s_axis_tvalid   (i_s_axis_tvalid),
        .i_s_axis_tlast    (i_s_axis_tlast),
        .o_s_axis_tready   (o_s_axis_tready),
        .i_frame_tick      (i_frame_tick),
        .i_frames_per_step (i_frames_per_step),
        .i_collision       (i_collision),
        .o_m_axis_tdata    (o_m_axis_tdata),
        .o_m_axis_tvalid   (o_m_axis_tvalid),
        .o_m_axis_tlast    (o_m_axis_tlast),
        .i_m_axis_tready   (i_m_axis_tready),
        .o_direction       (o_direction),
        .o_step_count      (o_step_count),
        .o_state           (o_state),
        .o_overrun         (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic bit is_reverse(input int a, input int b);
        return (a == 1 && b == 2) || (a == 2 && b == 1) || (a == 3 && b == 4) || (a == 4 && b == 3);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pend = 0; m_dir = 0; m_cnt = 0; m_steps = 0;
        m_valid = 0; m_over = 0; m_data = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int fe, op, d, eff, s_state, s_pend, s_dir, s_cnt;
        bit acc, step, drop, commit;
        fe  = (i_frames_per_step == 8'd0) ? 1 : int'(i_frames_per_step);
        acc = i_s_axis_tvalid && i_s_axis_tlast;
        op  = int'(i_s_axis_tdata[7:0]);
        d   = int'(i_s_axis_tdata[15:8]);
        step   = (m_state == 1) && i_frame_tick && (m_cnt == fe - 1) && !i_collision;
        drop   = step && m_valid && !i_m_axis_tready;
        commit = step && !drop;
        eff    = commit ? m_pend : m_dir;
        s_state = m_state; s_pend = m_pend; s_dir = m_dir; s_cnt = m_cnt;
        if (m_state == 1 && i_frame_tick) s_cnt = (m_cnt == fe - 1) ? 0 : m_cnt + 1;
        if (commit) begin
            m_steps = (m_steps + 1) % 65536;
            s_dir   = m_pend;
            m_data  = {32'h0, 16'(m_steps), 8'(m_pend), 8'h01};
            m_valid = 1;
        end else if (m_valid && i_m_axis_tready) begin
            m_valid = 0;
        end
        if (drop) m_over = 1;
        if (acc && op == 1 && (m_state == 1 || m_state == 2) && d >= 1 && d <= 4 && !is_reverse(d, eff))
            s_pend = d;
        if (i_collision) begin
            s_state = 3;
        end else if (acc) begin
            if (m_state == 0 && op == 1 && d >= 1 && d <= 4) begin
                s_state = 1; s_pend = d; s_dir = d; s_cnt = 0;
            end else if (m_state == 1 && op == 2) begin
                s_state = 2;
            end else if (m_state == 2 && op == 3) begin
                s_state = 1;
            end
        end
        m_state = s_state; m_pend = s_pend; m_dir = s_dir; m_cnt = s_cnt;
    endtask

    task automatic cycle();
        model_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_s_axis_tdata = '0; i_s_axis_tvalid = 1'b0; i_s_axis_tlast = 1'b0;
        i_frame_tick = 1'b0; i_frames_per_step = 8'd1; i_collision = 1'b0;
        i_m_axis_tready = 1'b1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic send(input int op, input int d);
        i_s_axis_tdata  = {48'h0, 8'(d), 8'(op)};
        i_s_axis_tvalid = 1'b1;
        i_s_axis_tlast  = 1'b1;
        cycle();
        i_s_axis_tvalid = 1'b0;
        i_s_axis_tlast  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            i_frame_tick = 1'b1; cycle();
            i_frame_tick = 1'b0; cycle();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b want 0", o_m_axis_tvalid); end
        n_cmp++; if (o_m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %0b want 0", o_m_axis_tlast); end
        n_cmp++; if (o_m_axis_tdata !== 64'h0) begin n_bad++; $display("FAIL reset_tdata: got %0h want 0", o_m_axis_tdata); end
        n_cmp++; if (o_direction !== 8'd0) begin n_bad++; $display("FAIL reset_dir: got %0d want 0", o_direction); end
        n_cmp++; if (o_step_count !== 16'd0) begin n_bad++; $display("FAIL reset_steps: got %0d want 0", o_step_count); end
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", o_state); end
        n_cmp++; if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %0b want 0", o_overrun); end
        n_cmp++; if (o_s_axis_tready !== 1'b1) begin n_bad++; $display("FAIL reset_s_tready: got %0b want 1", o_s_axis_tready); end
    endtask

    task automatic test_startup();
        do_reset();
        i_frames_per_step = 8'd3;
        send(1, 4);
        n_cmp++; if (o_state !== 2'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", o_state); end
        n_cmp++; if (o_direction !== 8'd4) begin n_bad++; $display("FAIL start_dir: got %0d want 4", o_direction); end
        ticks(2);
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL start_early: got %0b want 0", o_m_axis_tvalid); end
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL start_tvalid: got %0b want 1", o_m_axis_tvalid); end
        n_cmp++; if (o_m_axis_tlast !== 1'b1) begin n_bad++; $display("FAIL start_tlast: got %0b want 1", o_m_axis_tlast); end
        n_cmp++; if (o_m_axis_tdata !== 64'h0000_0000_0001_0401) begin n_bad++; $display("FAIL start_tdata: got %0h want 10401", o_m_axis_tdata); end
        n_cmp++; if (o_step_count !== 16'd1) begin n_bad++; $display("FAIL start_steps: got %0d want 1", o_step_count); end
        cycle();
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL start_handshake: got %0b want 0", o_m_axis_tvalid); end
    endtask

    task automatic test_reversal();
        send(1, 3);
        ticks(2);
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0002_0401) begin n_bad++; $display("FAIL rev_drop: got %0h want 20401", o_m_axis_tdata[31:0]); end
        cycle();
        send(1, 1);
        send(1, 2);
        n_cmp++; if (o_direction !== 8'd4) begin n_bad++; $display("FAIL rev_uncommitted: got %0d want 4", o_direction); end
        ticks(2);
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0003_0201) begin n_bad++; $display("FAIL rev_last_wins: got %0h want 30201", o_m_axis_tdata[31:0]); end
        n_cmp++; if (o_direction !== 8'd2) begin n_bad++; $display("FAIL rev_commit: got %0d want 2", o_direction); end
        cycle();
    endtask

    task automatic test_pause_resume();
        ticks(1);
        send(2, 0);
        n_cmp++; if (o_state !== 2'd2) begin n_bad++; $display("FAIL pause_state: got %0d want 2", o_state); end
        ticks(5);
        n_cmp++; if (o_step_count !== 16'd3) begin n_bad++; $display("FAIL pause_frozen: got %0d want 3", o_step_count); end
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL pause_no_out: got %0b want 0", o_m_axis_tvalid); end
        send(3, 0);
        n_cmp++; if (o_state !== 2'd1) begin n_bad++; $display("FAIL resume_state: got %0d want 1", o_state); end
        ticks(1);
        n_cmp++; if (o_step_count !== 16'd3) begin n_bad++; $display("FAIL resume_early: got %0d want 3", o_step_count); end
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_step_count !== 16'd4) begin n_bad++; $display("FAIL resume_step: got %0d want 4", o_step_count); end
        n_cmp++; if (o_m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL resume_tvalid: got %0b want 1", o_m_axis_tvalid); end
        cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        i_frames_per_step = 8'd2;
        send(1, 1);
        i_m_axis_tready = 1'b0;
        ticks(1);
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tdata !== 64'h0000_0000_0001_0101) begin n_bad++; $display("FAIL bp_first: got %0h want 10101", o_m_axis_tdata); end
        cycle();
        ticks(1);
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tdata !== 64'h0000_0000_0001_0101) begin n_bad++; $display("FAIL bp_hold: got %0h want 10101", o_m_axis_tdata); end
        n_cmp++; if (o_m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_tvalid: got %0b want 1", o_m_axis_tvalid); end
        n_cmp++; if (o_overrun !== 1'b1) begin n_bad++; $display("FAIL bp_overrun: got %0b want 1", o_overrun); end
        n_cmp++; if (o_step_count !== 16'd1) begin n_bad++; $display("FAIL bp_steps: got %0d want 1", o_step_count); end
        // Asynchronous reset between clock edges drops the held packet at once.
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL async_tvalid: got %0b want 0", o_m_axis_tvalid); end
        n_cmp++; if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL async_overrun: got %0b want 0", o_overrun); end
    endtask

    task automatic test_collision();
        do_reset();
        i_frames_per_step = 8'd2;
        send(1, 3);
        ticks(1);
        i_collision = 1'b1; i_frame_tick = 1'b1; cycle();
        i_collision = 1'b0; i_frame_tick = 1'b0;
        n_cmp++; if (o_state !== 2'd3) begin n_bad++; $display("FAIL coll_state: got %0d want 3", o_state); end
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL coll_no_step: got %0b want 0", o_m_axis_tvalid); end
        send(1, 4);
        send(3, 0);
        ticks(4);
        n_cmp++; if (o_state !== 2'd3) begin n_bad++; $display("FAIL coll_sticky: got %0d want 3", o_state); end
        n_cmp++; if (o_step_count !== 16'd0) begin n_bad++; $display("FAIL coll_steps: got %0d want 0", o_step_count); end
        n_cmp++; if (o_direction !== 8'd3) begin n_bad++; $display("FAIL coll_dir: got %0d want 3", o_direction); end
        // A packet already on the bus survives the collision until accepted.
        do_reset();
        i_frames_per_step = 8'd0;
        i_m_axis_tready = 1'b0;
        send(1, 1);
        i_frame_tick = 1'b1; cycle();
        i_collision = 1'b1; cycle();
        i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL coll_hold: got %0b want 1", o_m_axis_tvalid); end
        n_cmp++; if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL coll_overrun: got %0b want 0", o_overrun); end
        i_m_axis_tready = 1'b1; cycle();
        n_cmp++; if (o_m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL coll_drain: got %0b want 0", o_m_axis_tvalid); end
        i_collision = 1'b0;
    endtask

    task automatic test_edge_cases();
        do_reset();
        i_frames_per_step = 8'd0;
        send(7, 1);
        send(1, 5);
        send(2, 0);
        n_cmp++; if (o_state !== 2'd0) begin n_bad++; $display("FAIL edge_idle: got %0d want 0", o_state); end
        send(1, 2);
        i_frame_tick = 1'b1; cycle();
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0001_0201) begin n_bad++; $display("FAIL edge_fps0_a: got %0h want 10201", o_m_axis_tdata[31:0]); end
        cycle();
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0002_0201) begin n_bad++; $display("FAIL edge_fps0_b: got %0h want 20201", o_m_axis_tdata[31:0]); end
        n_cmp++; if (o_m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL edge_reload: got %0b want 1", o_m_axis_tvalid); end
        i_frame_tick = 1'b0;
        i_s_axis_tdata = {48'h0, 8'd3, 8'd1}; i_s_axis_tvalid = 1'b1; i_s_axis_tlast = 1'b0;
        cycle();
        i_s_axis_tvalid = 1'b0;
        send(1, 5);
        send(7, 3);
        send(1, 1);
        // PAUSE arriving with a step tick: the step fires first.
        i_s_axis_tdata = {48'h0, 8'd0, 8'd2}; i_s_axis_tvalid = 1'b1; i_s_axis_tlast = 1'b1;
        i_frame_tick = 1'b1; cycle();
        i_s_axis_tvalid = 1'b0; i_s_axis_tlast = 1'b0; i_frame_tick = 1'b0;
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0003_0201) begin n_bad++; $display("FAIL edge_ignored: got %0h want 30201", o_m_axis_tdata[31:0]); end
        n_cmp++; if (o_state !== 2'd2) begin n_bad++; $display("FAIL edge_pause_tick: got %0d want 2", o_state); end
        send(1, 3);
        send(3, 0);
        i_frame_tick = 1'b1; cycle(); i_frame_tick = 1'b0;
        n_cmp++; if (o_direction !== 8'd3) begin n_bad++; $display("FAIL edge_pause_latch: got %0d want 3", o_direction); end
        n_cmp++; if (o_step_count !== 16'd4) begin n_bad++; $display("FAIL edge_steps: got %0d want 4", o_step_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        i_frames_per_step = 8'd0;
        send(1, 4);
        i_frame_tick = 1'b1;
        for (int i = 0; i < 65535; i++) cycle();
        n_cmp++; if (o_step_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_max: got %0h want ffff", o_step_count); end
        cycle();
        i_frame_tick = 1'b0;
        n_cmp++; if (o_step_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero: got %0h want 0", o_step_count); end
        n_cmp++; if (o_m_axis_tdata[31:0] !== 32'h0000_0401) begin n_bad++; $display("FAIL wrap_tdata: got %0h want 401", o_m_axis_tdata[31:0]); end
        n_cmp++; if (o_step_count !== 16'(m_steps)) begin n_bad++; $display("FAIL wrap_model: got %0h want %0h", o_step_count, 16'(m_steps)); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int coll_at;
            do_reset();
            i_frames_per_step = 8'($urandom_range(0, 3));
            coll_at = (r >= 2) ? int'($urandom_range(600, 1100)) : 100000;
            for (int c = 0; c < 1200; c++) begin
                int sel, op;
                sel = int'($urandom_range(0, 9));
                op  = (sel < 5) ? 1 : (sel < 7) ? 2 : (sel < 9) ? 3 : 7;
                i_s_axis_tdata  = {32'($urandom), 16'($urandom), 8'($urandom_range(0, 5)), 8'(op)};
                i_s_axis_tvalid = ($urandom_range(0, 99) < 30);
                i_s_axis_tlast  = ($urandom_range(0, 3) != 0);
                i_frame_tick    = ($urandom_range(0, 1) == 1);
                i_m_axis_tready = ($urandom_range(0, 9) < 7);
                i_collision     = (c >= coll_at);
                cycle();
                n_cmp++; if (o_state !== 2'(m_state)) begin n_bad++; $display("FAIL rnd_state r%0d c%0d: got %0d want %0d", r, c, o_state, m_state); end
                n_cmp++; if (o_m_axis_tvalid !== m_valid) begin n_bad++; $display("FAIL rnd_tvalid r%0d c%0d: got %0b want %0b", r, c, o_m_axis_tvalid, m_valid); end
                n_cmp++; if (o_m_axis_tlast !== m_valid) begin n_bad++; $display("FAIL rnd_tlast r%0d c%0d: got %0b want %0b", r, c, o_m_axis_tlast, m_valid); end
                n_cmp++; if (o_m_axis_tdata !== m_data) begin n_bad++; $display("FAIL rnd_tdata r%0d c%0d: got %0h want %0h", r, c, o_m_axis_tdata, m_data); end
                n_cmp++; if (o_direction !== 8'(m_dir)) begin n_bad++; $display("FAIL rnd_dir r%0d c%0d: got %0d want %0d", r, c, o_direction, m_dir); end
                n_cmp++; if (o_step_count !== 16'(m_steps)) begin n_bad++; $display("FAIL rnd_steps r%0d c%0d: got %0d want %0d", r, c, o_step_count, m_steps); end
                n_cmp++; if (o_overrun !== m_over) begin n_bad++; $display("FAIL rnd_overrun r%0d c%0d: got %0b want %0b", r, c, o_overrun, m_over); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_reversal();
        test_pause_resume();
        test_backpressure();
        test_collision();
        test_edge_cases();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
